// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, legal oversampling ratios and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 32;

  // Parity bit for a word: even parity when odd=0, odd parity when odd=1.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-word outputs.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
                  input  P_DATA, Data_Valid, PAR_ERR, STP_ERR);
  modport slave  (input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
                  output P_DATA, Data_Valid, PAR_ERR, STP_ERR);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and 3-sample majority vote.
// o_bit_end marks the last oversample of a bit; o_sampled_bit is stable
// from edge_cnt = P/2+2 onwards.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_sampled_bit,
  output logic                  o_bit_end
);
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [2:0]            r_smp;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half        = i_prescale >> 1;
  assign w_last        = i_prescale - PRESCALE_W'(1);
  assign o_bit_end     = i_run && (r_edge_cnt == w_last);
  assign o_sampled_bit = (r_smp[0] & r_smp[1]) | (r_smp[1] & r_smp[2]) |
                         (r_smp[0] & r_smp[2]);

  // Oversample counter: held at 0 while idle, wraps at the end of each bit.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_edge_cnt <= '0;
    else if (!i_run)    r_edge_cnt <= '0;
    else if (o_bit_end) r_edge_cnt <= '0;
    else                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
  end

  // Capture the line at the three mid-bit sample points.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_smp <= 3'b111;
    else if (i_run) begin
      if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_smp[0] <= i_rx;
      if (r_edge_cnt == w_half)                  r_smp[1] <= i_rx;
      if (r_edge_cnt == w_half + PRESCALE_W'(1)) r_smp[2] <= i_rx;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART frame receiver (start, DATA_WIDTH bits LSB-first, optional
// parity, one stop). Compile-time switch UART_RX_SYNC_EN inserts a 2-flop
// synchroniser on RX_IN (adds 2 cycles of latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic       CLK,
  input  logic       RST,
  uart_rx_if.slave   bus
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             r_state;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_fail;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_dv, r_perr, r_serr;

  logic                  w_rx;
  logic                  w_run;
  logic                  w_sampled;
  logic                  w_bit_end;
  logic [PRESCALE_W-1:0] w_prescale;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;
  // Two-flop synchroniser, idle-high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], bus.RX_IN};
  end
  assign w_rx = r_sync[1];
`else
  assign w_rx = bus.RX_IN;
`endif

  // In IDLE the live PRESCALE is used so the start cycle sees current config.
  assign w_prescale = (r_state == IDLE) ? bus.PRESCALE : r_prescale;
  assign w_run      = (r_state != IDLE) || !w_rx;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_rx         (w_rx),
    .i_run        (w_run),
    .i_prescale   (w_prescale),
    .o_sampled_bit(w_sampled),
    .o_bit_end    (w_bit_end)
  );

  // Frame FSM with data path and registered result strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_fail <= 1'b0;
      r_prescale <= PRESCALE_W'(PRESCALE_8);
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_p_data   <= '0;
      r_dv       <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_perr <= 1'b0;
      r_serr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_prescale <= bus.PRESCALE;
          r_par_en   <= bus.PAR_EN;
          r_par_typ  <= bus.PAR_TYP;
          r_bit_cnt  <= '0;
          r_par_fail <= 1'b0;
          if (!w_rx) r_state <= START;
        end
        START: if (w_bit_end) r_state <= w_sampled ? IDLE : DATA;
        DATA: if (w_bit_end) begin
          r_shift <= {w_sampled, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_cnt == BCW'(DATA_WIDTH-1)) begin
            r_bit_cnt <= '0;
            r_state   <= r_par_en ? PARITY : STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
        end
        PARITY: if (w_bit_end) begin
          r_par_fail <= w_sampled != calc_parity(PAR_MAX_W'(r_shift), r_par_typ);
          r_state    <= STOP;
        end
        STOP: if (w_bit_end) begin
          if (!w_sampled)     r_serr <= 1'b1;
          else if (r_par_fail) r_perr <= 1'b1;
          else begin
            r_p_data <= r_shift;
            r_dv     <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.Data_Valid = r_dv;
  assign bus.PAR_ERR    = r_perr;
  assign bus.STP_ERR    = r_serr;
endmodule
